// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes,
// default filter length and the host-to-device frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_RELEASE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    localparam int PS2_FILTER_LEN = 8;

    // b0..b7 data LSB first, b8 odd parity, b9 stop
    function automatic logic [9:0] ps2_frame(
        input logic [7:0] d
    );
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-flop synchronizer plus run-length hysteresis.
// Ports: clk, reset_n, pin_in (raw) -> level (filtered), fall (1-cycle pulse).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle PS/2 lines are high, so reset to 1 to avoid a false edge.
    // The level flips only on the FILTER_LEN-th consecutive
    // differing sample; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (RTS, 11-bit frame, ack check).
// Ports: tx_* handshake, raw pin inputs, open-drain pull-low drives, busy/done/err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                        ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state, nxt;

    logic [9:0]    frame;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic          data_low;
    logic          ack_err;
    logic [1:0]    dsync;
    logic          data_s;
    logic          clk_lvl;
    logic          clk_fall;
    logic          accept;
    logic          to_hit;
    logic          rel_ok;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_in  (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dsync <= 2'b11;
        else          dsync <= {dsync[0], ps2_data_in};
    end

    assign data_s   = dsync[1];
    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign rel_ok   = clk_lvl && data_s;
    assign to_hit   = (state inside {ST_RTS, ST_SHIFT, ST_ACK})
                   && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:    if (accept) nxt = ST_INHIBIT;
            ST_INHIBIT: if (cnt == INH_LAST) nxt = ST_RTS;
            ST_RTS:     if (to_hit) nxt = ST_IDLE;
                        else if (clk_fall) nxt = ST_SHIFT;
            ST_SHIFT:   if (to_hit) nxt = ST_IDLE;
                        else if (clk_fall && idx == 4'd9) nxt = ST_ACK;
            ST_ACK:     if (to_hit) nxt = ST_IDLE;
                        else if (clk_fall) nxt = ST_RELEASE;
            ST_RELEASE: if (rel_ok) nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // One counter serves both the inhibit interval and the
    // RTS-to-ack timeout; it restarts when the clock is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame    <= '0;
            idx      <= '0;
            cnt      <= '0;
            data_low <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    data_low <= 1'b0;
                    cnt      <= '0;
                    if (accept) begin
                        frame   <= ps2_frame(tx_data);
                        ack_err <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt      <= '0;
                        data_low <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RTS: begin
                    cnt <= cnt + 1'b1;
                    if (clk_fall) begin
                        data_low <= ~frame[0];
                        idx      <= 4'd1;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (clk_fall) begin
                        data_low <= ~frame[idx];
                        idx      <= idx + 1'b1;
                    end
                end
                ST_ACK: begin
                    cnt <= cnt + 1'b1;
                    if (clk_fall) ack_err <= data_s;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ps2_clk_drive_low  = 1'b0;
        ps2_data_drive_low = 1'b0;
        done               = 1'b0;
        err                = 1'b0;
        unique case (state)
            ST_INHIBIT: begin
                ps2_clk_drive_low  = 1'b1;
                ps2_data_drive_low = (cnt == INH_LAST);
            end
            ST_RTS, ST_SHIFT, ST_ACK: begin
                ps2_data_drive_low = data_low && !to_hit;
                done               = to_hit;
                err                = to_hit;
            end
            ST_RELEASE: begin
                done = rel_ok;
                err  = rel_ok && ack_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device.
// Device clocks at 2*H system cycles per bit, samples on rising edges.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TO  = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       clk_dl;
    logic       data_dl;
    logic       busy;
    logic       done;
    logic       err;
    logic       dev_clk;
    logic       dev_data;

    int checks = 0;
    int errors = 0;

    assign ps2_clk_in  = dev_clk  & ~clk_dl;
    assign ps2_data_in = dev_data & ~data_dl;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (8)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clk_drive_low  (clk_dl),
        .ps2_data_drive_low (data_dl),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Accept a byte, then follow the inhibit phase to the
    // first RTS cycle. A second request mid-inhibit must be ignored.
    task automatic start(input logic [7:0] b);
        int   inh;
        logic prev;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("busy_n1", busy, 1);
        chk("clkdl_n1", clk_dl, 1);
        chk("ready_n1", tx_ready, 0);
        chk("data_n1", data_dl, 0);
        inh  = 1;
        prev = data_dl;
        while (inh < 10000) begin
            if (inh == 3) begin
                tx_valid = 1'b1;
                tx_data  = ~b;
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
            if (clk_dl !== 1'b1) break;
            inh++;
            prev = data_dl;
        end
        tx_valid = 1'b0;
        chk("inhibit_len", inh, INH);
        chk("start_before_release", prev, 1);
        chk("start_in_rts", data_dl, 1);
    endtask

    // got[0]=start, got[1..8]=data, got[9]=parity, got[10]=stop
    task automatic device(input bit ack, input bit glitch,
                          input int abort_fall,
                          output logic [10:0] got);
        got = '0;
        if (glitch) begin
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (7) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        got[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ~ack;
            dev_clk = 1'b0;
            if (k == abort_fall) begin
                repeat (15) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (k == 11) begin
                dev_data = 1'b1;
                return;
            end
            got[k] = ps2_data_in;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic finish_xfer(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_clkdl"}, clk_dl, 0);
        chk({tag, "_datadl"}, data_dl, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, tx_ready, 1);
        chk({tag, "_done_width"}, done, 0);
    endtask

    initial begin
        logic [10:0] got;
        int          n;

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clkdl", clk_dl, 0);
        chk("rst_datadl", data_dl, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // 0xED: data 1,0,1,1,0,1,1,1 parity 1
        start(8'hED);
        device(1'b1, 1'b0, 0, got);
        chk("frame_ED", got, {1'b1, 1'b1, 8'hED, 1'b0});
        finish_xfer("ED", 1'b0);

        // 0x01 parity 0, with a 7-cycle clock glitch before bit 0
        start(8'h01);
        device(1'b1, 1'b1, 0, got);
        chk("frame_01", got, {1'b1, 1'b0, 8'h01, 1'b0});
        finish_xfer("01", 1'b0);

        start(8'hFF);
        device(1'b1, 1'b0, 0, got);
        chk("frame_FF", got, {1'b1, 1'b1, 8'hFF, 1'b0});
        finish_xfer("FF", 1'b0);

        // Device never clocks: timeout on RTS cycle TO-1
        start(8'h55);
        n = 0;
        while (done !== 1'b1 && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TO - 1);
        finish_xfer("timeout", 1'b1);

        // Device skips the ack
        start(8'h3C);
        device(1'b0, 1'b0, 0, got);
        chk("frame_3C", got, {1'b1, 1'b1, 8'h3C, 1'b0});
        finish_xfer("noack", 1'b1);

        // Reset during bit 4 of 0x00 (bit low, so data is pulled)
        start(8'h00);
        device(1'b1, 1'b0, 5, got);
        chk("bit4_datadl", data_dl, 1);
        chk("bit4_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_clkdl", clk_dl, 0);
        chk("midrst_datadl", data_dl, 0);
        chk("midrst_busy", busy, 0);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", tx_ready, 1);

        start(PS2_F4());
        device(1'b1, 1'b0, 0, got);
        chk("frame_F4", got, {1'b1, 1'b0, 8'hF4, 1'b0});
        finish_xfer("F4", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    function automatic logic [7:0] PS2_F4();
        return ps2_pkg::PS2_CMD_ENABLE;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
